// File: rtl/wave_sequencer_if.sv
// Control, table-write and generator-side signals of the wave sequencer.
// The master drives requests and writes; the slave returns generator controls.
interface wave_sequencer_if #(
  parameter int AW = 2
);
  logic          start;
  logic          stop;
  logic          loop;
  logic [AW-1:0] last_step;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_amplitude;
  logic [15:0]   wr_prescaler;
  logic [15:0]   wr_duration;
  logic          gen_ena;
  logic [15:0]   gen_amplitude;
  logic [15:0]   gen_prescaler;
  logic [AW-1:0] step_idx;
  logic          busy;
  logic          done;

  modport master (
    output start, stop, loop, last_step,
    output wr_en, wr_addr,
    output wr_amplitude, wr_prescaler, wr_duration,
    input  gen_ena, gen_amplitude, gen_prescaler,
    input  step_idx, busy, done
  );

  modport slave (
    input  start, stop, loop, last_step,
    input  wr_en, wr_addr,
    input  wr_amplitude, wr_prescaler, wr_duration,
    output gen_ena, gen_amplitude, gen_prescaler,
    output step_idx, busy, done
  );
endinterface

// File: rtl/wave_sequencer.sv
// Step-table sequencer driving a sawtooth generator: each step is a
// one-cycle LOAD (phase clear) followed by a RUN of max(duration,1) cycles.
module wave_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic            rst,
  wave_sequencer_if.slave sq
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [15:0]   amp_mem [DEPTH];
  logic [15:0]   pre_mem [DEPTH];
  logic [15:0]   dur_mem [DEPTH];

  logic [AW-1:0] step_q, step_d;
  logic [AW-1:0] last_q, last_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   amp_q, amp_d;
  logic [15:0]   pre_q, pre_d;
  logic          ena_q, ena_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        amp_mem[i] <= '0;
        pre_mem[i] <= '0;
        dur_mem[i] <= '0;
      end
    end else if (sq.wr_en) begin
      amp_mem[sq.wr_addr] <= sq.wr_amplitude;
      pre_mem[sq.wr_addr] <= sq.wr_prescaler;
      dur_mem[sq.wr_addr] <= sq.wr_duration;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      amp_q   <= '0;
      pre_q   <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      amp_q   <= amp_d;
      pre_q   <= pre_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    amp_d   = amp_q;
    pre_d   = pre_q;
    ena_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sq.start && !sq.stop) begin
          state_d = LOAD;
          step_d  = '0;
          last_d  = sq.last_step;
        end
      end
      LOAD: begin
        if (sq.stop) begin
          state_d = IDLE;
        end else begin
          amp_d   = amp_mem[step_q];
          pre_d   = pre_mem[step_q];
          cnt_d   = (dur_mem[step_q] == '0) ? 16'd1
                                            : dur_mem[step_q];
          ena_d   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // cnt_q counts the RUN cycles still owed, including this one
        if (sq.stop) begin
          state_d = IDLE;
        end else if (cnt_q > 16'd1) begin
          cnt_d = cnt_q - 16'd1;
          ena_d = 1'b1;
        end else if (step_q != last_q) begin
          step_d  = step_q + AW'(1);
          state_d = LOAD;
        end else if (sq.loop) begin
          step_d  = '0;
          state_d = LOAD;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign sq.gen_ena       = ena_q;
  assign sq.gen_amplitude = amp_q;
  assign sq.gen_prescaler = pre_q;
  assign sq.step_idx      = step_q;
  assign sq.busy          = busy_q;
  assign sq.done          = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer: basic, loop/stop, zero duration,
// write hazards, busy start and asynchronous reset mid-run.
module tb_wave_sequencer;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  wave_sequencer_if #(.AW(2)) sq ();

  wave_sequencer #(
    .DEPTH(4),
    .AW   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sq (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [15:0] amp,
                    input logic [15:0] pre,
                    input logic [15:0] dur);
    sq.wr_en        = 1'b1;
    sq.wr_addr      = a;
    sq.wr_amplitude = amp;
    sq.wr_prescaler = pre;
    sq.wr_duration  = dur;
    tick();
    sq.wr_en = 1'b0;
  endtask

  // observed vector: {ena,busy,done,step[1:0],amp,pre}
  function automatic logic [36:0] obs();
    return {sq.gen_ena, sq.busy, sq.done, sq.step_idx,
            sq.gen_amplitude, sq.gen_prescaler};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_chk++;
    if (obs() !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=%h", obs(), 37'd0);
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if (obs() !== 37'd0) begin
      n_fail++;
      $display("FAIL after_reset got=%h want=%h", obs(), 37'd0);
    end
  endtask

  task automatic test_basic();
    logic [36:0] ev [9];
    ev = '{
      {3'b010, 2'd0, 16'd0,   16'd0},
      {3'b110, 2'd0, 16'd100, 16'd2},
      {3'b110, 2'd0, 16'd100, 16'd2},
      {3'b110, 2'd0, 16'd100, 16'd2},
      {3'b010, 2'd1, 16'd100, 16'd2},
      {3'b110, 2'd1, 16'd50,  16'd0},
      {3'b110, 2'd1, 16'd50,  16'd0},
      {3'b001, 2'd1, 16'd50,  16'd0},
      {3'b000, 2'd1, 16'd50,  16'd0}
    };
    wr(2'd0, 16'd100, 16'd2, 16'd3);
    wr(2'd1, 16'd50, 16'd0, 16'd2);
    sq.last_step = 2'd1;
    sq.loop      = 1'b0;
    sq.start     = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      sq.start = 1'b0;
      n_chk++;
      if (obs() !== ev[c]) begin
        n_fail++;
        $display("FAIL basic_c%0d got=%h want=%h", c + 1, obs(), ev[c]);
      end
    end
  endtask

  task automatic test_loop_stop();
    logic [36:0] ev [9];
    ev = '{
      {3'b010, 2'd0, 16'd50,  16'd0},
      {3'b110, 2'd0, 16'd100, 16'd2},
      {3'b110, 2'd0, 16'd100, 16'd2},
      {3'b110, 2'd0, 16'd100, 16'd2},
      {3'b010, 2'd1, 16'd100, 16'd2},
      {3'b110, 2'd1, 16'd50,  16'd0},
      {3'b110, 2'd1, 16'd50,  16'd0},
      {3'b010, 2'd0, 16'd50,  16'd0},
      {3'b110, 2'd0, 16'd100, 16'd2}
    };
    sq.loop  = 1'b1;
    sq.start = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      sq.start = 1'b0;
      n_chk++;
      if (obs() !== ev[c]) begin
        n_fail++;
        $display("FAIL loop_c%0d got=%h want=%h", c + 1, obs(), ev[c]);
      end
    end
    sq.stop = 1'b1;
    tick();
    sq.stop = 1'b0;
    n_chk++;
    if (obs() !== {3'b000, 2'd0, 16'd100, 16'd2}) begin
      n_fail++;
      $display("FAIL stop_midrun got=%h want=%h", obs(),
               {3'b000, 2'd0, 16'd100, 16'd2});
    end
    sq.start = 1'b1;
    sq.stop  = 1'b1;
    tick();
    sq.start = 1'b0;
    sq.stop  = 1'b0;
    n_chk++;
    if (sq.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_over_start busy got=%b want=0", sq.busy);
    end
  endtask

  task automatic test_zero_duration();
    logic [36:0] ev [4];
    ev = '{
      {3'b010, 2'd0, 16'd100, 16'd2},
      {3'b110, 2'd0, 16'd7,   16'd9},
      {3'b001, 2'd0, 16'd7,   16'd9},
      {3'b000, 2'd0, 16'd7,   16'd9}
    };
    wr(2'd0, 16'd7, 16'd9, 16'd0);
    sq.last_step = 2'd0;
    sq.loop      = 1'b0;
    sq.start     = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      sq.start = 1'b0;
      n_chk++;
      if (obs() !== ev[c]) begin
        n_fail++;
        $display("FAIL zero_c%0d got=%h want=%h", c + 1, obs(), ev[c]);
      end
    end
  endtask

  task automatic test_write_hazard();
    logic [15:0] amp1;
    logic [1:0]  s_exp;
    logic        e_exp;
    int          p;
    int          m;
    wr(2'd0, 16'd100, 16'd2, 16'd3);
    sq.last_step = 2'd1;
    sq.loop      = 1'b1;
    sq.start     = 1'b1;
    tick();
    sq.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      sq.wr_en = 1'b0;
      sq.start = 1'b0;
      sq.last_step = 2'd1;
      if (n == 3) begin
        sq.start     = 1'b1;
        sq.last_step = 2'd0;
      end
      if (n == 6 || n == 12) begin
        sq.wr_en        = 1'b1;
        sq.wr_addr      = 2'd1;
        sq.wr_amplitude = (n == 6) ? 16'd60 : 16'd70;
        sq.wr_prescaler = 16'd0;
        sq.wr_duration  = 16'd2;
      end
      tick();
      m = n + 1;
      p = (m - 1) % 7;
      amp1 = ((m - 1) / 7 == 0) ? 16'd50 :
             ((m - 1) / 7 == 1) ? 16'd60 : 16'd70;
      s_exp = (p >= 4) ? 2'd1 : 2'd0;
      e_exp = (p != 0 && p != 4);
      n_chk++;
      if ({sq.gen_ena, sq.busy, sq.step_idx} !== {e_exp, 1'b1, s_exp}) begin
        n_fail++;
        $display("FAIL hazard_ctl_c%0d got=%b%b%0d want=%b1%0d", m,
                 sq.gen_ena, sq.busy, sq.step_idx, e_exp, s_exp);
      end
      if (e_exp) begin
        n_chk++;
        if (sq.gen_amplitude !== ((p >= 4) ? amp1 : 16'd100)) begin
          n_fail++;
          $display("FAIL hazard_amp_c%0d got=%0d want=%0d", m,
                   sq.gen_amplitude, (p >= 4) ? amp1 : 16'd100);
        end
      end
    end
    sq.wr_en = 1'b0;
    sq.stop  = 1'b1;
    tick();
    sq.stop = 1'b0;
    n_chk++;
    if ({sq.gen_ena, sq.busy, sq.done} !== 3'b000) begin
      n_fail++;
      $display("FAIL hazard_stop got=%b want=000",
               {sq.gen_ena, sq.busy, sq.done});
    end
  endtask

  task automatic test_reset_midrun();
    sq.last_step = 2'd1;
    sq.loop      = 1'b0;
    sq.start     = 1'b1;
    tick();
    sq.start = 1'b0;
    tick();
    n_chk++;
    if (sq.gen_ena !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_run got=%b want=1", sq.gen_ena);
    end
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (obs() !== 37'd0) begin
      n_fail++;
      $display("FAIL async_reset got=%h want=%h", obs(), 37'd0);
    end
    #1 rst = 1'b0;
    sq.last_step = 2'd0;
    sq.start     = 1'b1;
    tick();
    sq.start = 1'b0;
    n_chk++;
    if (obs() !== {3'b010, 2'd0, 16'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL first_start got=%h want=%h", obs(),
               {3'b010, 2'd0, 16'd0, 16'd0});
    end
    tick();
    n_chk++;
    if (obs() !== {3'b110, 2'd0, 16'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL cleared_table got=%h want=%h", obs(),
               {3'b110, 2'd0, 16'd0, 16'd0});
    end
    tick();
    n_chk++;
    if (obs() !== {3'b001, 2'd0, 16'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL cleared_done got=%h want=%h", obs(),
               {3'b001, 2'd0, 16'd0, 16'd0});
    end
  endtask

  initial begin
    n_chk           = 0;
    n_fail          = 0;
    rst             = 1'b1;
    sq.start        = 1'b0;
    sq.stop         = 1'b0;
    sq.loop         = 1'b0;
    sq.last_step    = '0;
    sq.wr_en        = 1'b0;
    sq.wr_addr      = '0;
    sq.wr_amplitude = '0;
    sq.wr_prescaler = '0;
    sq.wr_duration  = '0;
    test_reset();
    test_basic();
    test_loop_stop();
    test_zero_duration();
    test_write_hazard();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_sequencer.md
WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of step-table entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 2, meaning step-index width, log2(DEPTH).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sequence.
REQ-006 SHALL have port stop  input  1  one-cycle request to abort the sequence.
REQ-007 SHALL have port loop  input  1  level; 1 means restart at step 0 after the last step.
REQ-008 SHALL have port last_step  input  AW  index of the final step; sampled on the accepted start.
REQ-009 SHALL have port wr_en  input  1  table write strobe.
REQ-010 SHALL have port wr_addr  input  AW  table entry to write.
REQ-011 SHALL have port wr_amplitude  input  16  amplitude field for the write.
REQ-012 SHALL have port wr_prescaler  input  16  prescaler field for the write.
REQ-013 SHALL have port wr_duration  input  16  step length in clk cycles for the write.
REQ-014 SHALL have port gen_ena  output  1  enable to the sawtooth generator.
REQ-015 SHALL have port gen_amplitude  output  16  amplitude to the generator.
REQ-016 SHALL have port gen_prescaler  output  16  prescaler to the generator.
REQ-017 SHALL have port step_idx  output  AW  index of the current or most recent step.
REQ-018 SHALL have port busy  output  1  high in LOAD and RUN.
REQ-019 SHALL have port done  output  1  one-cycle pulse on normal sequence completion.

Function
REQ-020 SHALL store DEPTH entries of {amplitude, prescaler, duration}; a write with wr_en=1 updates entry wr_addr on the clock edge, in any state.
REQ-021 SHALL be a three-state FSM: IDLE, LOAD, RUN; all outputs registered.
REQ-022 IDLE: gen_ena=0, busy=0; start=1 with stop=0 SHALL move to LOAD with step_idx=0 and last_step captured.
REQ-023 LOAD (exactly one cycle): gen_ena=0; SHALL latch the entry at step_idx into gen_amplitude and gen_prescaler and load the duration counter, then move to RUN.
REQ-024 The gen_ena=0 cycle in LOAD SHALL clear the generator's phase between steps.
REQ-025 RUN: gen_ena=1 for exactly max(duration,1) consecutive cycles; duration 0 SHALL be treated as 1.
REQ-026 At the end of RUN with step_idx<last_step, the FSM SHALL go to LOAD with step_idx+1.
REQ-027 At the end of RUN with step_idx==last_step and loop=1, the FSM SHALL go to LOAD with step_idx=0 and no done pulse.
REQ-028 At the end of RUN with step_idx==last_step and loop=0, the FSM SHALL go to IDLE with done=1 for that single cycle.
REQ-029 stop=1 in LOAD or RUN SHALL force IDLE on the next edge with gen_ena=0 and no done; stop has priority over start and over step advance.
REQ-030 start while busy SHALL be ignored; last_step changes while busy SHALL be ignored.
REQ-031 LOAD SHALL read the table value held before the edge; a same-cycle write to that entry takes effect only at a later LOAD.
REQ-032 In IDLE, gen_amplitude, gen_prescaler and step_idx SHALL hold their last values.
REQ-033 The duration counter SHALL be 16-bit and SHALL never wrap during a step.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, all outputs to 0, the duration counter to 0 and all table entries to 0, including mid-RUN.
REQ-035 After rst deasserts, the first start SHALL be accepted on the next clk edge.

Verification
REQ-036 Basic: entry0={100,2,3}, entry1={50,0,2}, last_step=1, loop=0, start at edge 0 -> LOAD edge1; gen_ena=1 edges 2-4 with amp=100; LOAD edge5; gen_ena=1 edges 6-7 with amp=50; edge8 IDLE with done=1 for one cycle.
REQ-037 Loop: same table, loop=1 -> after step1, LOAD with step_idx=0, no done; stop mid-RUN -> gen_ena=0 next cycle, busy=0, done=0.
REQ-038 Zero duration: entry0 duration=0, last_step=0 -> exactly one gen_ena=1 cycle, then done.
REQ-039 Write hazards: rewrite entry1 during step1 RUN and during its LOAD cycle -> new value appears only on the next pass; start while busy has no effect.
REQ-040 Reset mid-RUN: assert rst asynchronously -> gen_ena, busy, step_idx and gen_* go to 0 without a clk edge; the table reads 0 on the next sequence.
